// File: rtl/cam_capture_ctrl.sv
// Capture sequencer between the camera pixel reader and the frame-buffer RAM write port.
// Forwards only whole frames, validates pixel count, and swaps banks after good frames.
module cam_capture_ctrl #(
  parameter int AW         = 15,
  parameter int DW         = 12,
  parameter int IMG_PIXELS = 19200
) (
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          cap_start,
  input  logic          cap_stop,
  input  logic          cap_cont,
  input  logic          in_regW,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          wr_bank,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err,
  output logic [7:0]    frame_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [AW:0] IMG_CNT = (AW+1)'(IMG_PIXELS);

  state_t        state_q, state_d;
  logic          vsync_q;
  logic          mode_q, mode_d;
  logic          stop_q, stop_d;
  logic [AW:0]   pix_q, pix_d;
  logic          regW_q, regW_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          bank_q, bank_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          fall, rise;

  assign fall = ~CAM_vsync & vsync_q;
  assign rise = CAM_vsync & ~vsync_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    stop_d  = stop_q;
    pix_d   = pix_q;
    regW_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    bank_d  = bank_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cap_start && !cap_stop) begin
          mode_d  = cap_cont;
          stop_d  = 1'b0;
          state_d = ARMED;
        end
      end
      ARMED: begin
        // Only a blanking->active edge starts a frame, so partial frames never reach RAM.
        if (cap_stop) begin
          state_d = IDLE;
        end else if (fall) begin
          pix_d   = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        regW_d = in_regW;
        addr_d = in_addr;
        data_d = in_data;
        if (in_regW && (pix_q != '1)) pix_d = pix_q + 1'b1;
        if (cap_stop) stop_d = 1'b1;
        if (rise) state_d = DONE;
      end
      DONE: begin
        done_d = 1'b1;
        err_d  = (pix_q != IMG_CNT);
        cnt_d  = cnt_q + 8'd1;
        if (!err_d) bank_d = ~bank_q;
        state_d = (mode_q && !stop_q && !cap_stop) ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CAM_pclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      mode_q  <= 1'b0;
      stop_q  <= 1'b0;
      pix_q   <= '0;
      regW_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      bank_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= CAM_vsync;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
      pix_q   <= pix_d;
      regW_q  <= regW_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign DP_RAM_regW    = regW_q;
  assign DP_RAM_addr_in = addr_q;
  assign DP_RAM_data_in = data_q;
  assign wr_bank        = bank_q;
  assign busy           = (state_q != IDLE);
  assign frame_done     = done_q;
  assign frame_err      = err_q;
  assign frame_cnt      = cnt_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl with a 16-pixel frame and 5-bit addresses.
module tb_cam_capture_ctrl;

  localparam int AW  = 5;
  localparam int DW  = 12;
  localparam int IMG = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync, cap_start, cap_stop, cap_cont, in_regW;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          regW, wr_bank, busy, frame_done, frame_err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [7:0]    frame_cnt;

  int total = 0;
  int bad   = 0;
  logic       exp_bank;
  logic [7:0] exp_cnt;

  cam_capture_ctrl #(.AW(AW), .DW(DW), .IMG_PIXELS(IMG)) dut (
    .CAM_pclk(clk), .rst(rst), .CAM_vsync(vsync),
    .cap_start(cap_start), .cap_stop(cap_stop), .cap_cont(cap_cont),
    .in_regW(in_regW), .in_addr(in_addr), .in_data(in_data),
    .DP_RAM_regW(regW), .DP_RAM_addr_in(ram_addr), .DP_RAM_data_in(ram_data),
    .wr_bank(wr_bank), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         nwr;
    logic       exp_err;
    logic       exp_bank;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input logic cont);
    cap_start = 1'b1;
    cap_cont  = cont;
    tick();
    cap_start = 1'b0;
    cap_cont  = 1'b0;
  endtask

  // Fall edge, then n writes; the last write shares its cycle with the rising vsync edge.
  task automatic run_frame(input int n, input int stop_at);
    vsync = 1'b0;
    tick();
    check("regW_idle_before_write", regW, 0);
    for (int i = 0; i < n; i++) begin
      in_regW  = 1'b1;
      in_addr  = AW'(i);
      in_data  = DW'(i * 7 + 3);
      cap_stop = (i == stop_at);
      if (i == n - 1) vsync = 1'b1;
      tick();
      check("regW_echo", regW, 1);
      check("addr_echo", ram_addr, i);
      check("data_echo", ram_data, DW'(i * 7 + 3));
    end
    in_regW  = 1'b0;
    cap_stop = 1'b0;
    check("no_done_early", frame_done, 0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_bank = 1'b0;
    exp_cnt  = 8'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{nwr: 16, exp_err: 1'b0, exp_bank: 1'b1, exp_cnt: 8'd1};
    vecs[1] = '{nwr: 12, exp_err: 1'b1, exp_bank: 1'b1, exp_cnt: 8'd2};
    vecs[2] = '{nwr: 17, exp_err: 1'b1, exp_bank: 1'b1, exp_cnt: 8'd3};
    vecs[3] = '{nwr: 16, exp_err: 1'b0, exp_bank: 1'b0, exp_cnt: 8'd4};

    vsync = 1'b1; cap_start = 1'b0; cap_stop = 1'b0; cap_cont = 1'b0;
    in_regW = 1'b0; in_addr = '0; in_data = '0;
    do_reset();
    check("rst_regW", regW, 0);
    check("rst_busy", busy, 0);
    check("rst_bank", wr_bank, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_done", frame_done, 0);
    check("rst_addr", ram_addr, 0);

    // Single-shot frames: good, short, long, good.
    for (int v = 0; v < 4; v++) begin
      start(1'b0);
      check("busy_armed", busy, 1);
      tick();
      run_frame(vecs[v].nwr, -1);
      check("ss_done", frame_done, 1);
      check("ss_err", frame_err, vecs[v].exp_err);
      check("ss_bank", wr_bank, vecs[v].exp_bank);
      check("ss_cnt", frame_cnt, vecs[v].exp_cnt);
      check("ss_busy", busy, 0);
      check("ss_regW_done", regW, 0);
      tick();
      check("ss_done_pulse", frame_done, 0);
      check("ss_err_clear", frame_err, 0);
    end

    // Arm during an active frame: its remaining writes are blocked.
    vsync = 1'b0;
    tick();
    tick();
    start(1'b0);
    for (int i = 0; i < 5; i++) begin
      in_regW = 1'b1;
      in_addr = AW'(20 + i);
      tick();
      check("midarm_blocked", regW, 0);
    end
    in_regW = 1'b0;
    vsync = 1'b1;
    tick();
    check("midarm_still_armed", busy, 1);
    run_frame(16, -1);
    check("midarm_done", frame_done, 1);
    check("midarm_err", frame_err, 0);
    check("midarm_bank", wr_bank, 1);
    check("midarm_cnt", frame_cnt, 5);
    tick();

    // Continuous: three good frames, stop during the fourth.
    do_reset();
    start(1'b1);
    tick();
    for (int f = 0; f < 4; f++) begin
      run_frame(16, (f == 3) ? 8 : -1);
      exp_bank = ~exp_bank;
      exp_cnt  = exp_cnt + 8'd1;
      check("cont_done", frame_done, 1);
      check("cont_err", frame_err, 0);
      check("cont_bank", wr_bank, exp_bank);
      check("cont_cnt", frame_cnt, exp_cnt);
      check("cont_busy", busy, (f < 3) ? 1 : 0);
      tick();
      check("cont_done_pulse", frame_done, 0);
    end

    // Start and stop together in IDLE: stop wins.
    cap_start = 1'b1; cap_stop = 1'b1;
    tick();
    cap_start = 1'b0; cap_stop = 1'b0;
    check("prio_idle", busy, 0);
    // Stop while armed: back to IDLE, nothing forwarded.
    start(1'b0);
    check("prio_armed", busy, 1);
    cap_stop = 1'b1;
    tick();
    cap_stop = 1'b0;
    check("stop_armed", busy, 0);
    vsync = 1'b0;
    tick();
    in_regW = 1'b1;
    tick();
    check("stop_no_write", regW, 0);
    in_regW = 1'b0;
    vsync = 1'b1;
    tick();

    // Asynchronous reset in the middle of a frame.
    start(1'b0);
    tick();
    vsync = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      in_regW = 1'b1;
      in_addr = AW'(i);
      in_data = DW'(i + 1);
      tick();
    end
    check("pre_rst_regW", regW, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_regW", regW, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_bank", wr_bank, 0);
    check("async_rst_cnt", frame_cnt, 0);
    check("async_rst_addr", ram_addr, 0);
    check("async_rst_data", ram_data, 0);
    in_regW = 1'b0;
    vsync = 1'b1;
    #1 rst = 1'b0;
    tick();
    start(1'b0);
    tick();
    run_frame(16, -1);
    check("post_rst_done", frame_done, 1);
    check("post_rst_err", frame_err, 0);
    check("post_rst_bank", wr_bank, 1);
    check("post_rst_cnt", frame_cnt, 1);
    check("post_rst_busy", busy, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
